fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set address/instruction width.
REQ-002 Parameter DEPTH, default 4, SHALL set instruction buffer entries and the limit on outstanding fetches; legal values are powers of two, minimum 2.
REQ-003 Parameter RESET_PC, default 32'h0, SHALL set the PC loaded at reset.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  rising-edge clock.
REQ-006 i_reset  in  1  asynchronous active-low reset.
REQ-007 o_imem_req  out  1  fetch request valid.
REQ-008 o_imem_addr  out  XLEN  word-aligned fetch address.
REQ-009 i_imem_gnt  in  1  memory accepts request this cycle.
REQ-010 i_imem_rvalid  in  1  in-order response valid.
REQ-011 i_imem_rdata  in  XLEN  response instruction word.
REQ-012 o_insn_vld  out  1  o_insn/o_pc valid to decode.
REQ-013 o_insn  out  XLEN  buffered instruction at head.
REQ-014 o_pc  out  XLEN  PC of o_insn.
REQ-015 i_insn_ready  in  1  decode consumes head this cycle.
REQ-016 i_redirect  in  1  branch/jump redirect strobe.
REQ-017 i_redirect_pc  in  XLEN  redirect target.
REQ-018 o_pc_debug  out  XLEN  current fetch PC (next address to request).

Function
REQ-019 Fetch PC, head PC, buffer count, outstanding count and drop count SHALL be registers; the buffer SHALL be a DEPTH-entry circular FIFO with wrapping read/write pointers.
REQ-020 o_imem_req SHALL be 1 iff (outstanding + count) < DEPTH and i_redirect = 0; o_imem_addr SHALL equal the fetch PC.
REQ-021 A request is issued when o_imem_req & i_imem_gnt: fetch PC += 4 (modulo 2^XLEN), outstanding += 1.
REQ-022 Responses SHALL be in order; each i_imem_rvalid decrements outstanding; i_imem_rvalid with outstanding = 0 SHALL be ignored.
REQ-023 A response with drop count > 0 SHALL be discarded and decrement drop count; otherwise i_imem_rdata SHALL be written to the FIFO.
REQ-024 A written word SHALL be visible on o_insn no earlier than the cycle after i_imem_rvalid (no bypass).
REQ-025 o_insn_vld SHALL be (count != 0) & ~i_redirect; o_insn and o_pc SHALL remain stable while o_insn_vld = 1 and i_insn_ready = 0.
REQ-026 A dequeue occurs when o_insn_vld & i_insn_ready: read pointer advances and head PC += 4.
REQ-027 Simultaneous write and dequeue SHALL leave count unchanged; the REQ-020 limit SHALL guarantee the FIFO never overflows.
REQ-028 On i_redirect = 1: fetch PC and head PC <= {i_redirect_pc[XLEN-1:2], 2'b00}; count and pointers <= 0; drop count <= outstanding minus any response arriving that cycle; no request and no dequeue SHALL occur that cycle.
REQ-029 Throughput SHALL be one instruction per cycle when i_imem_gnt = 1, response latency is 1 and i_insn_ready = 1.

Reset
REQ-030 While i_reset = 0: fetch PC = head PC = RESET_PC; count, outstanding, drop count and pointers = 0; o_imem_req = 0; o_insn_vld = 0; o_imem_addr = o_pc = o_pc_debug = RESET_PC; o_insn = 0.
REQ-031 Reset asserted mid-operation SHALL abandon all buffered and outstanding fetches; responses after release with outstanding = 0 SHALL be ignored.
REQ-032 First request SHALL be issued in the first clock edge after reset release.

Verification
REQ-033 DEPTH=4, RESET_PC=0, gnt=1, response latency 1, ready=1 -> o_imem_addr 0,4,8,...; o_pc 0,4,8,... one per cycle, first o_insn_vld 2 cycles after the first request.
REQ-034 ready=0 from reset -> exactly 4 requests issued, o_imem_req stays 0, count=4, o_pc=0 held 20 cycles; ready=1 -> o_pc 0,4,8,12 on consecutive cycles and requests resume.
REQ-035 Two outstanding requests (addr 8, 12), i_redirect with pc=0x100 -> both responses discarded, next request addr 0x100, first o_pc=0x100 with the 0x100 data.
REQ-036 Redirect to 0x103 -> o_imem_addr=0x100, o_pc=0x100; redirect in the same cycle as a response -> drop count excludes that response.
REQ-037 gnt toggling 1/0 with 3-cycle latency -> no lost or duplicated instructions, o_pc strictly +4, outstanding+count never exceeds 4.
REQ-038 i_reset pulsed low with 3 outstanding and 1 buffered -> all outputs at reset values immediately; stale rvalid after release ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, buffers the in-order responses
// in a small FIFO and hands them to decode with their PC. Redirects flush the buffer.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_insn_vld,
    output logic [XLEN-1:0] o_insn,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_insn_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_pc_debug
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be a power of two and at least 2");
    end

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] buf_q [DEPTH];
    ptr_t            wptr;
    ptr_t            rptr;
    cnt_t            count;
    cnt_t            outstanding;
    cnt_t            drop_cnt;

    logic [CW:0]     inflight;
    logic            issue;
    logic            rsp;
    logic            rsp_drop;
    logic            wr_en;
    logic            deq;
    logic [XLEN-1:0] redir_pc;
    logic [1:0]      unused_redir_lsb;

    // Credit check covers both buffered words and words still in flight, so every
    // response that comes back always has a free FIFO slot waiting for it.
    assign inflight   = {1'b0, outstanding} + {1'b0, count};
    assign o_imem_req = i_reset && (inflight < DEPTH_W) && !i_redirect;
    assign issue      = o_imem_req && i_imem_gnt;

    // Responses with nothing outstanding are stale (e.g. from before a reset).
    assign rsp      = i_imem_rvalid && (outstanding != '0);
    assign rsp_drop = rsp && (drop_cnt != '0);
    assign wr_en    = rsp && !rsp_drop && !i_redirect;

    assign o_insn_vld = (count != '0) && !i_redirect;
    assign deq        = o_insn_vld && i_insn_ready;

    assign redir_pc         = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsb = i_redirect_pc[1:0];

    assign o_imem_addr = fetch_pc;
    assign o_pc_debug  = fetch_pc;
    assign o_pc        = head_pc;
    assign o_insn      = (count != '0) ? buf_q[rptr] : '0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(issue) - cnt_t'(rsp);
            if (i_redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redir_pc;
                head_pc  <= redir_pc;
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                drop_cnt <= outstanding - cnt_t'(rsp);
            end else begin
                if (issue) fetch_pc <= fetch_pc + INSN_BYTES;
                if (deq)   head_pc  <= head_pc + INSN_BYTES;
                wptr     <= wptr + ptr_t'(wr_en);
                rptr     <= rptr + ptr_t'(deq);
                count    <= count + cnt_t'(wr_en) - cnt_t'(deq);
                drop_cnt <= drop_cnt - cnt_t'(rsp_drop);
            end
        end
    end

    // Storage needs no reset: o_insn is masked whenever the buffer is empty.
    always_ff @(posedge i_clk) begin
        if (wr_en) buf_q[wptr] <= i_imem_rdata;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers granted fetches in order,
// directed phases push expected PCs, and a monitor checks every dequeued instruction.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_insn_vld;
    logic [31:0] o_insn;
    logic [31:0] o_pc;
    logic        i_insn_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_pc_debug;

    fetch_unit dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_insn_vld    (o_insn_vld),
        .o_insn        (o_insn),
        .o_pc          (o_pc),
        .i_insn_ready  (i_insn_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_pc_debug    (o_pc_debug)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory model knobs (driven by the stimulus process)
    int unsigned lat = 1;
    bit          gnt_on = 1'b1;
    bit          gnt_toggle = 1'b0;
    bit          hold = 1'b0;
    bit          inject = 1'b0;

    int unsigned cyc = 0;
    int unsigned n_req = 0;
    logic [31:0] addr_q[$];
    int unsigned due_q[$];

    int unsigned n_pop = 0;
    int          mon_total = 0;
    int          mon_bad = 0;
    int          drv_total = 0;
    int          drv_bad = 0;
    logic [31:0] exp_q[$];

    // Memory: drive response/grant at negedge+1, capture the request at negedge+2.
    always @(negedge i_clk) begin
        logic [31:0] a;
        cyc++;
        #1;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        if (!i_reset) begin
            addr_q.delete();
            due_q.delete();
        end else if (inject) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = 32'hDEAD_BEEF;
        end else if (!hold && addr_q.size() > 0 && due_q[0] <= cyc) begin
            a = addr_q.pop_front();
            void'(due_q.pop_front());
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = word_at(a);
        end
        i_imem_gnt = gnt_toggle ? cyc[0] : gnt_on;
        #1;
        if (o_imem_req && i_imem_gnt) begin
            addr_q.push_back(o_imem_addr);
            due_q.push_back(cyc + lat);
            n_req++;
        end
    end

    // Monitor: every dequeue is checked against the head of the expected queue.
    always @(negedge i_clk) begin
        logic [31:0] e;
        #3;
        if (o_insn_vld && i_insn_ready) begin
            n_pop++;
            mon_total++;
            if (exp_q.size() == 0) begin
                mon_bad++;
                $display("FAIL mon_extra: got pc %0h, want no dequeue", o_pc);
            end else begin
                e = exp_q.pop_front();
                if (o_pc !== e || o_insn !== word_at(e)) begin
                    mon_bad++;
                    $display("FAIL mon_insn: got pc %0h insn %0h, want pc %0h insn %0h",
                             o_pc, o_insn, e, word_at(e));
                end
            end
        end
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        drv_total++;
        if (got !== want) begin
            drv_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},  {31'd0, o_imem_req}, 0);
        chk({tag, "_vld"},  {31'd0, o_insn_vld}, 0);
        chk({tag, "_addr"}, o_imem_addr, 0);
        chk({tag, "_pc"},   o_pc, 0);
        chk({tag, "_dbg"},  o_pc_debug, 0);
        chk({tag, "_insn"}, o_insn, 0);
    endtask

    task automatic enter_reset();
        tick();
        i_reset = 1'b0;
        i_redirect = 1'b0;
        i_insn_ready = 1'b0;
        hold = 1'b0;
        lat = 1;
        tick();
        tick();
    endtask

    int unsigned r0, p0;

    initial begin
        i_reset = 1'b1;
        i_insn_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        #2 i_reset = 1'b0;
        tick();
        #1 chk_reset_vals("rst");

        // A: streaming, latency 1, ready high
        tick();
        i_reset = 1'b1;
        i_insn_ready = 1'b1;
        p0 = n_pop;
        push_seq(32'h0, 19);
        repeat (21) tick();
        i_insn_ready = 1'b0;
        #4 chk("A_pops", n_pop - p0, 19);

        // B: decode stalled from reset, buffer fills, then drains back-to-back
        tick();
        i_reset = 1'b0;
        #1 chk_reset_vals("B_rst");
        tick();
        tick();
        i_reset = 1'b1;
        r0 = n_req;
        repeat (20) tick();
        #1;
        chk("B_reqs", n_req - r0, 4);
        chk("B_req_lo", {31'd0, o_imem_req}, 0);
        chk("B_vld", {31'd0, o_insn_vld}, 1);
        chk("B_pc_held", o_pc, 0);
        chk("B_dbg", o_pc_debug, 32'h10);
        i_insn_ready = 1'b1;
        p0 = n_pop;
        push_seq(32'h0, 10);
        repeat (10) tick();
        i_insn_ready = 1'b0;
        #4;
        chk("B_pops", n_pop - p0, 10);
        chk("B_resume", {31'd0, (n_req - r0) > 4}, 1);

        // C: redirect with two outstanding (8, 12), no response that cycle
        enter_reset();
        i_reset = 1'b1;
        repeat (3) tick();
        hold = 1'b1;
        repeat (2) tick();
        i_redirect = 1'b1;
        i_redirect_pc = 32'h100;
        #4;
        chk("C_redir_req", {31'd0, o_imem_req}, 0);
        chk("C_redir_vld", {31'd0, o_insn_vld}, 0);
        tick();
        i_redirect = 1'b0;
        hold = 1'b0;
        i_insn_ready = 1'b1;
        p0 = n_pop;
        push_seq(32'h100, 7);
        #4;
        chk("C_pc", o_pc, 32'h100);
        chk("C_addr", o_imem_addr, 32'h100);
        repeat (10) tick();
        i_insn_ready = 1'b0;
        #4 chk("C_pops", n_pop - p0, 7);

        // D: unaligned redirect target, response arriving in the redirect cycle
        enter_reset();
        i_reset = 1'b1;
        repeat (2) tick();
        hold = 1'b1;
        repeat (3) tick();
        hold = 1'b0;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h103;
        #4;
        chk("D_redir_req", {31'd0, o_imem_req}, 0);
        chk("D_redir_vld", {31'd0, o_insn_vld}, 0);
        tick();
        i_redirect = 1'b0;
        i_insn_ready = 1'b1;
        p0 = n_pop;
        push_seq(32'h100, 7);
        #4;
        chk("D_pc", o_pc, 32'h100);
        chk("D_addr", o_imem_addr, 32'h100);
        chk("D_dbg", o_pc_debug, 32'h100);
        repeat (10) tick();
        i_insn_ready = 1'b0;
        #4 chk("D_pops", n_pop - p0, 7);

        // F: reset with 3 outstanding + 1 buffered, stale response after release
        enter_reset();
        i_reset = 1'b1;
        lat = 3;
        repeat (4) tick();
        chk("F_pre_vld", {31'd0, o_insn_vld}, 1);
        chk("F_pre_req", {31'd0, o_imem_req}, 0);
        chk("F_pre_dbg", o_pc_debug, 32'h10);
        i_reset = 1'b0;
        #3 chk_reset_vals("F_rst");
        tick();
        tick();
        i_reset = 1'b1;
        inject = 1'b1;
        lat = 1;
        i_insn_ready = 1'b1;
        p0 = n_pop;
        push_seq(32'h0, 6);
        tick();
        inject = 1'b0;
        #4 chk("F_stale_vld", {31'd0, o_insn_vld}, 0);
        repeat (7) tick();
        i_insn_ready = 1'b0;
        #4 chk("F_pops", n_pop - p0, 6);

        // E: grant toggling, latency 3, decode ready 2 of 3 cycles
        enter_reset();
        i_reset = 1'b1;
        lat = 3;
        gnt_toggle = 1'b1;
        i_insn_ready = 1'b1;
        r0 = n_req;
        p0 = n_pop;
        push_seq(32'h0, 200);
        for (int k = 0; k < 60; k++) begin
            tick();
            i_insn_ready = (k % 3 != 2);
            #4 chk("E_inflight", {31'd0, ((n_req - r0) - (n_pop - p0)) <= 4}, 1);
        end
        tick();
        gnt_toggle = 1'b0;
        gnt_on = 1'b0;
        i_insn_ready = 1'b1;
        repeat (25) tick();
        #4;
        chk("E_no_loss", n_pop - p0, n_req - r0);
        chk("E_drained", {31'd0, o_insn_vld}, 0);
        chk("E_progress", {31'd0, (n_req - r0) > 10}, 1);

        $display("test done: total=%0d bad=%0d", drv_total + mon_total, drv_bad + mon_bad);
        $finish;
    end

endmodule
